// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
        StMemWrite, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    // Instruction classes (Op field)
    localparam logic [1:0] OpDp      = 2'b00;
    localparam logic [1:0] OpMem     = 2'b01;
    localparam logic [1:0] OpBranch  = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    // ALUControl encodings
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluXor = 3'b010;
    localparam logic [2:0] AluRor = 3'b011;
    localparam logic [2:0] AluMov = 3'b100;

    // Data-processing cmd field values
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdEor = 4'b0001;
    localparam logic [3:0] CmdMov = 4'b1101;

    // Condition codes
    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

    // ResultSrc encodings
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluDirect = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // ALU operation for a data-processing instruction; MOV only exists in immediate form.
    function automatic logic [2:0] alu_decode(input logic i_bit, input logic [3:0] cmd);
        logic [2:0] ctl;
        case (cmd)
            CmdAdd:         ctl = AluAdd;
            CmdSub, CmdCmp: ctl = AluSub;
            CmdEor:         ctl = AluXor;
            CmdMov:         ctl = i_bit ? AluMov : AluRor;
            default:        ctl = AluAdd;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition evaluation and the architectural {N,Z,C,V} flag register.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;
    assign flags = flags_q;

    // Evaluate the condition field against the stored flags.
    always_comb begin
        case (cond)
            CondEq:  cond_ex = z;
            CondNe:  cond_ex = ~z;
            CondCs:  cond_ex = c;
            CondCc:  cond_ex = ~c;
            CondMi:  cond_ex = n;
            CondPl:  cond_ex = ~n;
            CondVs:  cond_ex = v;
            CondVc:  cond_ex = ~v;
            CondHi:  cond_ex = c & ~z;
            CondLs:  cond_ex = ~c | z;
            CondGe:  cond_ex = (n == v);
            CondLt:  cond_ex = (n != v);
            CondGt:  cond_ex = ~z & (n == v);
            CondLe:  cond_ex = z | (n != v);
            CondAl:  cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

    // Flag register; a failed condition suppresses the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            if (nz_we && cond_ex) flags_q[3:2] <= alu_flags[3:2];
            if (cv_we && cond_ex) flags_q[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_fsm.sv
// Multicycle ARM control FSM: Moore decode of state, gated by CondEx and MemReady.
module multicycle_fsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegW,
    output logic       MemW,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] Flags,
    output logic       Illegal
);

    state_e state_q;
    logic   cond_ex;
    logic   exec_state;
    logic   nz_we;
    logic   cv_we;
    logic   fetch_pc;
    logic   branch_pc;

    assign exec_state = (state_q == StExecR) || (state_q == StExecI);
    assign nz_we      = exec_state && Funct[0];
    assign cv_we      = nz_we && ((ALUControl == AluAdd) || (ALUControl == AluSub));
    assign Illegal    = !reset && (state_q == StDecode) && (Op == OpIllegal);

    cond_unit u_cond_unit (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .nz_we     (nz_we),
        .cv_we     (cv_we),
        .cond_ex   (cond_ex),
        .flags     (Flags)
    );

    // State register with next-state selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:    if (MemReady) state_q <= StDecode;
                StDecode: begin
                    case (Op)
                        OpDp:     state_q <= Funct[5] ? StExecI : StExecR;
                        OpMem:    state_q <= StMemAdr;
                        OpBranch: state_q <= StBranch;
                        default:  state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= Funct[0] ? StMemRead : StMemWrite;
                StMemRead:  if (MemReady) state_q <= StMemWb;
                StMemWrite: if (MemReady) state_q <= StFetch;
                // CMP only sets flags, so it skips writeback.
                StExecR, StExecI: state_q <= (Funct[4:1] == CmdCmp) ? StFetch : StAluWb;
                default:    state_q <= StFetch;
            endcase
        end
    end

    // Per-state datapath selects and write enables.
    always_comb begin
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBReg;
        ResultSrc  = ResAluOut;
        ALUControl = AluAdd;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        fetch_pc   = 1'b0;
        branch_pc  = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluDirect;
                IRWrite   = MemReady;
                fetch_pc  = MemReady;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluDirect;
            end
            StMemAdr:   ALUSrcB = SrcBImm;
            StMemRead:  AdrSrc = 1'b1;
            StMemWrite: begin
                AdrSrc = 1'b1;
                MemW   = cond_ex;
            end
            StMemWb: begin
                ResultSrc = ResReadData;
                RegW      = cond_ex;
            end
            StExecR:    ALUControl = alu_decode(Funct[5], Funct[4:1]);
            StExecI: begin
                ALUSrcB    = SrcBImm;
                ALUControl = alu_decode(Funct[5], Funct[4:1]);
            end
            StAluWb:    RegW = cond_ex;
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluDirect;
                branch_pc = cond_ex;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
        end
        // A register write to R15 also redirects the PC.
        PCWrite = !reset && (fetch_pc || branch_pc || (RegW && (Rd == 4'b1111)));
    end

    // Immediate and register-source selects depend only on the instruction class.
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (Op)
            OpMem: begin
                ImmSrc = 2'b01;
                RegSrc = Funct[0] ? 2'b00 : 2'b10;
            end
            OpBranch: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed, table-driven bench for multicycle_fsm.
module tb_multicycle_fsm;

    // Expected-state labels; SN means state not yet defined.
    typedef enum logic [3:0] {SN, SF, SD, SMA, SMR, SMB, SMW, SER, SEI, SAW, SB} st_e;

    typedef struct {
        logic       rst;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] aluf;
        logic       mr;
        st_e        st;
        logic [2:0] alu;
        logic [3:0] we;     // {PCWrite, IRWrite, RegW, MemW}
        logic       ill;
        logic [3:0] flags;
    } vec_t;

    localparam logic [3:0] AL = 4'hE;
    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] NE = 4'h1;
    localparam logic [2:0] AAdd = 3'b000, ASub = 3'b001, AXor = 3'b010;
    localparam logic [2:0] ARor = 3'b011, AMov = 3'b100;
    localparam logic [3:0] W0 = 4'b0000, WF = 4'b1100, WR = 4'b0010;
    localparam logic [3:0] WP = 4'b1000, WM = 4'b0001, WRP = 4'b1010;
    localparam logic [5:0] ADDI = 6'b101000, LDRF = 6'b011001, SUBS = 6'b000101;
    localparam logic [5:0] BF = 6'b100000, CMPF = 6'b010101, ADDR = 6'b001000;
    localparam logic [5:0] MOVS = 6'b111011, XORR = 6'b000010, RORR = 6'b011010;
    localparam logic [5:0] ORRI = 6'b111000, STRF = 6'b011000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'h0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'h0;
    logic [3:0] Rd = 4'h0;
    logic [3:0] ALUFlags = 4'h0;
    logic       MemReady = 1'b0;
    logic       PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];

    multicycle_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegW       (RegW),
        .MemW       (MemW),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want, input logic [31:0] msk);
        n_tests++;
        if (((got ^ want) & msk) !== 32'd0) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, want %h (mask %h)", name, idx, got, want, msk);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluf,
                       input logic mr, input st_e st, input logic [2:0] alu,
                       input logic [3:0] we, input logic ill, input logic [3:0] flags);
        vec_t v;
        v.rst = rst; v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.aluf = aluf;
        v.mr = mr; v.st = st; v.alu = alu; v.we = we; v.ill = ill; v.flags = flags;
        tbl.push_back(v);
    endtask

    task automatic drive_in(input logic rst, input logic [3:0] cond, input logic [1:0] op,
                            input logic [5:0] funct, input logic [3:0] rd,
                            input logic [3:0] aluf, input logic mr);
        reset = rst; Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = aluf;
        MemReady = mr;
    endtask

    // Expected {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} and which bits are defined.
    function automatic logic [17:0] exp_ctrl(input st_e st, input logic [2:0] alu);
        logic [8:0] val, msk;
        case (st)
            SF:       begin val = 9'b0_1_10_10_000; msk = 9'b1_1_11_11_111; end
            SD:       begin val = 9'b0_1_10_10_000; msk = 9'b0_1_11_11_000; end
            SMA:      begin val = 9'b0_0_01_00_000; msk = 9'b0_1_11_00_111; end
            SMR, SMW: begin val = 9'b1_0_00_00_000; msk = 9'b1_0_00_00_000; end
            SMB:      begin val = 9'b0_0_00_01_000; msk = 9'b0_0_00_11_000; end
            SER:      begin val = {6'b0_0_00_00, alu}; msk = 9'b0_1_11_00_111; end
            SEI:      begin val = {6'b0_0_01_00, alu}; msk = 9'b0_1_11_00_111; end
            SAW:      begin val = 9'b0_0_00_00_000; msk = 9'b0_0_00_11_000; end
            SB:       begin val = 9'b0_0_01_10_000; msk = 9'b0_1_11_11_111; end
            default:  begin val = 9'd0;             msk = 9'd0;             end
        endcase
        return {val, msk};
    endfunction

    // Expected {ImmSrc, RegSrc} from the instruction class.
    function automatic logic [3:0] exp_src(input logic [1:0] op, input logic l_bit);
        case (op)
            2'b01:   return l_bit ? 4'b01_00 : 4'b01_10;
            2'b10:   return 4'b10_01;
            default: return 4'b00_00;
        endcase
    endfunction

    task automatic check_row(input int i, input vec_t v);
        logic [17:0] c;
        chk("write_enables", i, 32'({PCWrite, IRWrite, RegW, MemW}), 32'(v.we), 32'hF);
        chk("illegal", i, 32'(Illegal), 32'(v.ill), 32'h1);
        chk("imm_reg_src", i, 32'({ImmSrc, RegSrc}), 32'(exp_src(v.op, v.funct[0])), 32'hF);
        if (v.st != SN) begin
            c = exp_ctrl(v.st, v.alu);
            chk("flags", i, 32'(Flags), 32'(v.flags), 32'hF);
            chk("ctrl", i, 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
                32'(c[17:9]), 32'(c[8:0]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rw;
        int rw_cnt;

        // Reset: write enables forced low even in FETCH with MemReady high.
        add(1, AL, 2'b00, ADDI, 4'd1, 4'h0, 0, SN, AAdd, W0, 0, 4'h0);
        add(1, AL, 2'b00, ADDI, 4'd1, 4'h0, 1, SF, AAdd, W0, 0, 4'h0);
        // ADD R1,R2,#5
        add(0, AL, 2'b00, ADDI, 4'd1, 4'h0, 1, SF,  AAdd, WF, 0, 4'h0);
        add(0, AL, 2'b00, ADDI, 4'd1, 4'h0, 1, SD,  AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b00, ADDI, 4'd1, 4'h0, 1, SEI, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b00, ADDI, 4'd1, 4'h0, 1, SAW, AAdd, WR, 0, 4'h0);
        // LDR, MEMREAD held four cycles
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 1, SF,  AAdd, WF, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SD,  AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 1, SMA, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SMR, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SMR, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SMR, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 1, SMR, AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SMB, AAdd, WR, 0, 4'h0);
        add(0, AL, 2'b01, LDRF, 4'd3, 4'h0, 0, SF,  AAdd, W0, 0, 4'h0);
        // SUBS with Z=1,C=1 then BEQ taken
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h6, 1, SF,  AAdd, WF, 0, 4'h0);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h6, 1, SD,  AAdd, W0, 0, 4'h0);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h6, 1, SER, ASub, W0, 0, 4'h0);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h6, 1, SAW, ASub, WR, 0, 4'h6);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h9, 1, SF,  AAdd, WF, 0, 4'h6);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h9, 1, SD,  AAdd, W0, 0, 4'h6);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h9, 1, SB,  AAdd, WP, 0, 4'h6);
        // SUBS with Z=0 then BEQ not taken
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h9, 1, SF,  AAdd, WF, 0, 4'h6);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h9, 1, SD,  AAdd, W0, 0, 4'h6);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h9, 1, SER, ASub, W0, 0, 4'h6);
        add(0, AL, 2'b00, SUBS, 4'd1, 4'h9, 1, SAW, ASub, WR, 0, 4'h9);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h0, 1, SF,  AAdd, WF, 0, 4'h9);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h0, 1, SD,  AAdd, W0, 0, 4'h9);
        add(0, EQ, 2'b10, BF,   4'd0, 4'h0, 1, SB,  AAdd, W0, 0, 4'h9);
        // CMP: no writeback, flags updated
        add(0, AL, 2'b00, CMPF, 4'd0, 4'h7, 1, SF,  AAdd, WF, 0, 4'h9);
        add(0, AL, 2'b00, CMPF, 4'd0, 4'h7, 1, SD,  AAdd, W0, 0, 4'h9);
        add(0, AL, 2'b00, CMPF, 4'd0, 4'h7, 1, SER, ASub, W0, 0, 4'h9);
        // ADD to R15: PCWrite with RegW
        add(0, AL, 2'b00, ADDR, 4'hF, 4'h7, 1, SF,  AAdd, WF,  0, 4'h7);
        add(0, AL, 2'b00, ADDR, 4'hF, 4'h7, 1, SD,  AAdd, W0,  0, 4'h7);
        add(0, AL, 2'b00, ADDR, 4'hF, 4'h7, 1, SER, AAdd, W0,  0, 4'h7);
        add(0, AL, 2'b00, ADDR, 4'hF, 4'h7, 1, SAW, AAdd, WRP, 0, 4'h7);
        // Same with NE while Z=1: no writes
        add(0, NE, 2'b00, ADDR, 4'hF, 4'h7, 1, SF,  AAdd, WF, 0, 4'h7);
        add(0, NE, 2'b00, ADDR, 4'hF, 4'h7, 1, SD,  AAdd, W0, 0, 4'h7);
        add(0, NE, 2'b00, ADDR, 4'hF, 4'h7, 1, SER, AAdd, W0, 0, 4'h7);
        add(0, NE, 2'b00, ADDR, 4'hF, 4'h7, 1, SAW, AAdd, W0, 0, 4'h7);
        // MOVS imm: N,Z load, C,V keep
        add(0, AL, 2'b00, MOVS, 4'd2, 4'hA, 1, SF,  AAdd, WF, 0, 4'h7);
        add(0, AL, 2'b00, MOVS, 4'd2, 4'hA, 1, SD,  AAdd, W0, 0, 4'h7);
        add(0, AL, 2'b00, MOVS, 4'd2, 4'hA, 1, SEI, AMov, W0, 0, 4'h7);
        add(0, AL, 2'b00, MOVS, 4'd2, 4'hA, 1, SAW, AMov, WR, 0, 4'hB);
        // XOR, ROR, other-cmd
        add(0, AL, 2'b00, XORR, 4'd2, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, AL, 2'b00, XORR, 4'd2, 4'h0, 1, SD,  AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b00, XORR, 4'd2, 4'h0, 1, SER, AXor, W0, 0, 4'hB);
        add(0, AL, 2'b00, XORR, 4'd2, 4'h0, 1, SAW, AXor, WR, 0, 4'hB);
        add(0, AL, 2'b00, RORR, 4'd2, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, AL, 2'b00, RORR, 4'd2, 4'h0, 1, SD,  AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b00, RORR, 4'd2, 4'h0, 1, SER, ARor, W0, 0, 4'hB);
        add(0, AL, 2'b00, RORR, 4'd2, 4'h0, 1, SAW, ARor, WR, 0, 4'hB);
        add(0, AL, 2'b00, ORRI, 4'd2, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, AL, 2'b00, ORRI, 4'd2, 4'h0, 1, SD,  AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b00, ORRI, 4'd2, 4'h0, 1, SEI, AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b00, ORRI, 4'd2, 4'h0, 1, SAW, AAdd, WR, 0, 4'hB);
        // STR with a wait cycle
        add(0, AL, 2'b01, STRF, 4'd4, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, AL, 2'b01, STRF, 4'd4, 4'h0, 0, SD,  AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b01, STRF, 4'd4, 4'h0, 0, SMA, AAdd, W0, 0, 4'hB);
        add(0, AL, 2'b01, STRF, 4'd4, 4'h0, 0, SMW, AAdd, WM, 0, 4'hB);
        add(0, AL, 2'b01, STRF, 4'd4, 4'h0, 1, SMW, AAdd, WM, 0, 4'hB);
        // STREQ while Z=0: no MemW
        add(0, EQ, 2'b01, STRF, 4'd4, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, EQ, 2'b01, STRF, 4'd4, 4'h0, 1, SD,  AAdd, W0, 0, 4'hB);
        add(0, EQ, 2'b01, STRF, 4'd4, 4'h0, 1, SMA, AAdd, W0, 0, 4'hB);
        add(0, EQ, 2'b01, STRF, 4'd4, 4'h0, 1, SMW, AAdd, W0, 0, 4'hB);
        // Illegal op
        add(0, AL, 2'b11, ADDR, 4'd0, 4'h0, 1, SF,  AAdd, WF, 0, 4'hB);
        add(0, AL, 2'b11, ADDR, 4'd0, 4'h0, 1, SD,  AAdd, W0, 1, 4'hB);
        add(0, AL, 2'b11, ADDR, 4'd0, 4'h0, 0, SF,  AAdd, W0, 0, 4'hB);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive_in(tbl[i].rst, tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd,
                     tbl[i].aluf, tbl[i].mr);
            @(negedge clk);
            check_row(i, tbl[i]);
        end

        // LDR: MemReady rises on the fourth MEMREAD cycle; RegW expected once, 7 cycles on.
        first_rw = -1;
        rw_cnt   = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            drive_in(1'b0, AL, 2'b01, LDRF, 4'd5, 4'h0, (c == 0) || (c == 6));
            @(negedge clk);
            if (RegW) begin
                rw_cnt++;
                if (first_rw < 0) first_rw = c;
            end
        end
        chk("ldr_regw_cycle", 0, 32'(first_rw), 32'd7, 32'hFFFF_FFFF);
        chk("ldr_regw_count", 0, 32'(rw_cnt), 32'd1, 32'hFFFF_FFFF);

        // Reset while MEMWRITE waits on memory.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            drive_in(c == 4, AL, 2'b01, STRF, 4'd4, 4'h0, (c == 0) || (c == 5));
            @(negedge clk);
            case (c)
                0: chk("str_fetch", c, 32'({PCWrite, IRWrite, RegW, MemW}), 32'(WF), 32'hF);
                3: chk("str_memw", c, 32'({PCWrite, IRWrite, RegW, MemW}), 32'(WM), 32'hF);
                4: chk("reset_in_memwrite", c, 32'({PCWrite, IRWrite, RegW, MemW}),
                       32'(W0), 32'hF);
                5: begin
                    chk("post_reset_fetch_we", c, 32'({PCWrite, IRWrite, RegW, MemW}),
                        32'(WF), 32'hF);
                    chk("post_reset_fetch_ctrl", c,
                        32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
                        32'(9'b0_1_10_10_000), 32'h1FF);
                    chk("post_reset_flags", c, 32'(Flags), 32'h0, 32'hF);
                end
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Cond  in  4  instruction condition field, Instr[31:28].
REQ-005 Op  in  2  instruction class: 00 DP, 01 LDR/STR, 10 B, 11 illegal.
REQ-006 Funct  in  6  Instr[25:20]: I bit, cmd[3:0], S/L bit.
REQ-007 Rd  in  4  destination register; 1111 means a PC write.
REQ-008 ALUFlags  in  4  current ALU flags {N,Z,C,V}.
REQ-009 MemReady  in  1  memory access complete this cycle.
REQ-010 PCWrite, IRWrite, RegW, MemW  out  1 each  write enables.
REQ-011 AdrSrc  out  1  memory address select: 0 PC, 1 ALU result.
REQ-012 ALUSrcA  out  1  ALU A select: 0 register, 1 PC.
REQ-013 ALUSrcB  out  2  ALU B select: 00 register, 01 extended immediate, 10 constant 4.
REQ-014 ResultSrc  out  2  result select: 00 ALUOut register, 01 read data, 10 ALU direct.
REQ-015 ImmSrc, RegSrc  out  2 each  decoded combinationally from Op, valid in every state.
REQ-016 ALUControl  out  3  000 ADD, 001 SUB, 010 XOR, 011 ROR, 100 MOV.
REQ-017 Flags  out  4  architectural flag register {N,Z,C,V}.
REQ-018 Illegal  out  1  one-cycle pulse in DECODE when Op=11.

Function
REQ-019 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH. Outputs are a Moore decode of the state, except where gated below.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. While MemReady=0, hold in FETCH with IRWrite=PCWrite=0. With MemReady=1, assert IRWrite=PCWrite=1 and go to DECODE.
REQ-021 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
 - Op=00 with Funct[5]=1 -> EXECI; Op=00 with Funct[5]=0 -> EXECR.
 - Op=01 -> MEMADR.
 - Op=10 -> BRANCH.
 - Op=11 -> FETCH with Illegal=1.
REQ-022 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
REQ-023 MEMREAD: AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
REQ-024 MEMWRITE: AdrSrc=1, MemW=CondEx. Hold with MemW asserted until MemReady=1, then go to FETCH.
REQ-025 MEMWB: ResultSrc=01, RegW=CondEx, then FETCH.
REQ-026 EXECR and EXECI:
 - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
 - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 1010 SUB, 0001 XOR, 1101 MOV if Funct[5]=1, else ROR; any other value ADD.
 - Next state: CMP (Funct[4:1]=1010) -> FETCH; otherwise -> ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegW=CondEx, then FETCH.
REQ-028 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx, then FETCH.
REQ-029 PC writes from a register result: when RegW=1 and Rd=1111, PCWrite is also asserted in the same cycle, gated by CondEx.
REQ-030 CondEx is combinational from Cond and the Flags register:
 - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
 - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
 - 1000 HI C&~Z; 1001 LS ~C|Z.
 - 1010 GE N==V; 1011 LT N!=V.
 - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
 - 1110 and 1111: always 1.
REQ-031 Flags update only at the end of EXECR/EXECI, and only when CondEx=1 and Funct[0]=1:
 - N and Z load from ALUFlags.
 - C and V load only when ALUControl is ADD or SUB.
REQ-032 ImmSrc/RegSrc decode: DP 00/00; LDR 01/00; STR 01/10; B 10/01; Op=11 00/00.
REQ-033 MemReady is ignored in all states other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-034 While reset=1: state<=FETCH, Flags<=0000, and PCWrite, IRWrite, RegW, MemW and Illegal are forced to 0 in that cycle.
REQ-035 The first cycle after reset deasserts is FETCH. Reset asserted mid-instruction abandons the instruction with no further write enables.

Structure
REQ-036 Package arm_ctrl_pkg SHALL hold the state enum, the ALUControl encodings, the condition-code constants and the ResultSrc/ALUSrcB encodings.
REQ-037 The condition evaluation and the Flags register SHALL be a single sub-module, cond_unit. The FSM and output decode stay in multicycle_fsm.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
 - ADD R1,R2,#5 (Op=00, Funct=101000, Cond=1110), MemReady=1 -> FETCH, DECODE, EXECI, ALUWB; RegW=1 only in ALUWB; 4 cycles total.
 - LDR with MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; RegW=1 once, in MEMWB.
 - SUBS, then BEQ (Cond=0000) with ALUFlags Z=1 -> Flags=x1xx; BRANCH asserts PCWrite=1. Repeat with Z=0 -> PCWrite=0.
 - CMP (Funct=010101) -> EXECR, then FETCH; no ALUWB and no RegW; Flags updated.
 - DP register op with Rd=1111 and Cond=AL -> PCWrite=1 and RegW=1 together in ALUWB.
 - Op=11 -> Illegal pulses 1 cycle in DECODE, then FETCH. Reset asserted in MEMWRITE with MemReady=0 -> MemW=0 that cycle; FETCH on the next cycle.
